// File: rtl/mem_arbiter.sv
// Two-port line-refill arbiter in front of a word-read memory.
// Each grant streams 2^WORD_OFFSET beats from memory to the owning requester.
// Beat valid, data and word index are forwarded combinationally.
// Simultaneous requests in IDLE are resolved by a round-robin pointer.
module mem_arbiter #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_c0,
    input  logic [ADR_WIDTH-1:0]   adr_c0,
    output logic                   ack_c0,
    output logic [DATA_WIDTH-1:0]  dat_c0,
    output logic [WORD_OFFSET-1:0] word_c0,
    input  logic                   req_c1,
    input  logic [ADR_WIDTH-1:0]   adr_c1,
    output logic                   ack_c1,
    output logic [DATA_WIDTH-1:0]  dat_c1,
    output logic [WORD_OFFSET-1:0] word_c1,
    output logic                   req_arb2mem,
    output logic [ADR_WIDTH-1:0]   adr_arb2mem,
    input  logic                   ack_mem2arb,
    input  logic [DATA_WIDTH-1:0]  dat_mem2arb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [WORD_OFFSET-1:0] C_CNT_LAST = {WORD_OFFSET{1'b1}};

    state_t                 r_state;
    logic [WORD_OFFSET-1:0] r_cnt;
    logic                   r_owner;
    logic                   r_rr;

    logic w_gnt0;
    logic w_gnt1;
    logic w_owner_req;
    logic w_other_req;

    assign w_gnt0      = (r_state == GNT0);
    assign w_gnt1      = (r_state == GNT1);
    assign w_owner_req = r_owner ? req_c1 : req_c0;
    assign w_other_req = r_owner ? req_c0 : req_c1;

    // Byte and in-line word bits of the requester addresses are replaced by
    // the beat counter, so they are intentionally not consumed.
    logic w_unused_adr_bits;
    assign w_unused_adr_bits = ^{adr_c0[WORD_OFFSET+1:0], adr_c1[WORD_OFFSET+1:0]};

    // Arbitration FSM: grant selection, beat counting and drain handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Both requesting: rr picks; otherwise the lone requester wins.
                    if (req_c0 && (!req_c1 || !r_rr)) begin
                        r_state <= GNT0;
                        r_owner <= 1'b0;
                        r_cnt   <= '0;
                    end else if (req_c1) begin
                        r_state <= GNT1;
                        r_owner <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                GNT0, GNT1: begin
                    // Burst always completes, even if the owner has dropped req.
                    if (ack_mem2arb) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_CNT_LAST) begin
                            r_state <= DRAIN;
                            r_rr    <= ~r_owner;
                        end
                    end
                end
                DRAIN: begin
                    // Wait for the owner to release; hand over directly if the
                    // other port is already waiting.
                    if (!w_owner_req) begin
                        if (w_other_req) begin
                            r_state <= r_owner ? GNT0 : GNT1;
                            r_owner <= ~r_owner;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory-side request: word address of the current beat while granted.
    always_comb begin
        req_arb2mem = w_gnt0 | w_gnt1;
        adr_arb2mem = '0;
        if (w_gnt0) begin
            adr_arb2mem = {adr_c0[ADR_WIDTH-1:WORD_OFFSET+2], r_cnt, 2'b00};
        end else if (w_gnt1) begin
            adr_arb2mem = {adr_c1[ADR_WIDTH-1:WORD_OFFSET+2], r_cnt, 2'b00};
        end
    end

    // Requester-side beat forwarding: only the owner sees acks; idle ports read 0.
    always_comb begin
        ack_c0  = w_gnt0 & ack_mem2arb;
        ack_c1  = w_gnt1 & ack_mem2arb;
        dat_c0  = ack_c0 ? dat_mem2arb : '0;
        dat_c1  = ack_c1 ? dat_mem2arb : '0;
        word_c0 = ack_c0 ? r_cnt : '0;
        word_c1 = ack_c1 ? r_cnt : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-port bursts and
// ignored acks, plus hand-written arbitration and reset sequences.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WO = 2;

    localparam logic [31:0] A0 = 32'h00CC_3B40;
    localparam logic [31:0] A1 = 32'h1234_567C;
    localparam logic [31:0] B1 = 32'h1234_5670;

    logic          clk;
    logic          rst;
    logic          req_c0, req_c1;
    logic [AW-1:0] adr_c0, adr_c1;
    logic          ack_c0, ack_c1;
    logic [DW-1:0] dat_c0, dat_c1;
    logic [WO-1:0] word_c0, word_c1;
    logic          req_arb2mem;
    logic [AW-1:0] adr_arb2mem;
    logic          ack_mem2arb;
    logic [DW-1:0] dat_mem2arb;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_OFFSET(WO)) dut (
        .clk(clk), .rst(rst),
        .req_c0(req_c0), .adr_c0(adr_c0), .ack_c0(ack_c0), .dat_c0(dat_c0), .word_c0(word_c0),
        .req_c1(req_c1), .adr_c1(adr_c1), .ack_c1(ack_c1), .dat_c1(dat_c1), .word_c1(word_c1),
        .req_arb2mem(req_arb2mem), .adr_arb2mem(adr_arb2mem),
        .ack_mem2arb(ack_mem2arb), .dat_mem2arb(dat_mem2arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          r0;
        bit          r1;
        bit          ack;
        logic [31:0] dat;
        bit          e_req;
        logic [31:0] e_adr;
        bit          e_a0;
        bit          e_a1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [1:0]  e_w0;
        logic [1:0]  e_w1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r0, input bit r1, input bit ack, input logic [31:0] dat,
                       input bit e_req, input logic [31:0] e_adr, input bit e_a0, input bit e_a1,
                       input logic [31:0] e_d0, input logic [31:0] e_d1,
                       input logic [1:0] e_w0, input logic [1:0] e_w1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.ack = ack; v.dat = dat;
        v.e_req = e_req; v.e_adr = e_adr; v.e_a0 = e_a0; v.e_a1 = e_a1;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_w0 = e_w0; v.e_w1 = e_w1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit e_req, input logic [31:0] e_adr,
                             input bit e_a0, input bit e_a1,
                             input logic [31:0] e_d0, input logic [31:0] e_d1,
                             input logic [1:0] e_w0, input logic [1:0] e_w1);
        chk({tag, ".req_mem"}, {31'd0, req_arb2mem}, {31'd0, e_req});
        chk({tag, ".adr_mem"}, adr_arb2mem, e_adr);
        chk({tag, ".ack_c0"}, {31'd0, ack_c0}, {31'd0, e_a0});
        chk({tag, ".ack_c1"}, {31'd0, ack_c1}, {31'd0, e_a1});
        chk({tag, ".dat_c0"}, dat_c0, e_d0);
        chk({tag, ".dat_c1"}, dat_c1, e_d1);
        chk({tag, ".word_c0"}, {30'd0, word_c0}, {30'd0, e_w0});
        chk({tag, ".word_c1"}, {30'd0, word_c1}, {30'd0, e_w1});
        $display("[TB] %s req_mem=%0b adr=%h ack0=%0b ack1=%0b", tag, req_arb2mem,
                 adr_arb2mem, ack_c0, ack_c1);
    endtask

    // Drive inputs just after a rising edge, then move to the falling edge to sample.
    task automatic drive(input bit r0, input bit r1, input bit ack, input logic [31:0] dat);
        req_c0 = r0; req_c1 = r1; ack_mem2arb = ack; dat_mem2arb = dat;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req_c0 = 0; req_c1 = 0; ack_mem2arb = 0; dat_mem2arb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // One full line for 'port' with an ack every cycle; the FSM must already be in GNT.
    task automatic burst(input string tag, input int port, input bit r0, input bit r1,
                         input logic [31:0] base);
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            drive(r0, r1, 1'b1, d);
            if (port == 0)
                check_all($sformatf("%s.b%0d", tag, k), 1'b1, base + 32'(4 * k), 1'b1, 1'b0,
                          d, 32'd0, 2'(k), 2'd0);
            else
                check_all($sformatf("%s.b%0d", tag, k), 1'b1, base + 32'(4 * k), 1'b0, 1'b1,
                          32'd0, d, 2'd0, 2'(k));
            tick();
        end
        ack_mem2arb = 1'b0;
    endtask

    initial begin
        adr_c0 = A0;
        adr_c1 = A1;
        rst = 1'b0; req_c0 = 0; req_c1 = 0; ack_mem2arb = 1'b1; dat_mem2arb = 32'hFFFF_FFFF;
        #3;
        check_all("reset", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 2'd0);
        do_reset();

        // Port 0 burst with a wait state, ignored acks in DRAIN/IDLE, then a
        // port 1 burst whose requester drops req after word 1.
        add(1,0,0,32'h0,          0,32'h0,     0,0,32'h0,32'h0,0,0);
        add(1,0,0,32'h0,          1,A0,        0,0,32'h0,32'h0,0,0);
        add(1,0,1,32'hD000_0000,  1,A0,        1,0,32'hD000_0000,32'h0,0,0);
        add(1,0,1,32'hD000_0001,  1,A0+4,      1,0,32'hD000_0001,32'h0,1,0);
        add(1,0,0,32'h0,          1,A0+8,      0,0,32'h0,32'h0,0,0);
        add(1,0,1,32'hD000_0002,  1,A0+8,      1,0,32'hD000_0002,32'h0,2,0);
        add(1,0,1,32'hD000_0003,  1,A0+12,     1,0,32'hD000_0003,32'h0,3,0);
        add(1,0,1,32'hD000_0004,  0,32'h0,     0,0,32'h0,32'h0,0,0);
        add(0,0,0,32'h0,          0,32'h0,     0,0,32'h0,32'h0,0,0);
        add(0,0,1,32'hD000_0005,  0,32'h0,     0,0,32'h0,32'h0,0,0);
        add(0,1,0,32'h0,          0,32'h0,     0,0,32'h0,32'h0,0,0);
        add(0,1,0,32'h0,          1,B1,        0,0,32'h0,32'h0,0,0);
        add(0,1,1,32'hE000_0000,  1,B1,        0,1,32'h0,32'hE000_0000,0,0);
        add(0,1,1,32'hE000_0001,  1,B1+4,      0,1,32'h0,32'hE000_0001,0,1);
        add(0,0,0,32'h0,          1,B1+8,      0,0,32'h0,32'h0,0,0);
        add(0,0,1,32'hE000_0002,  1,B1+8,      0,1,32'h0,32'hE000_0002,0,2);
        add(0,0,1,32'hE000_0003,  1,B1+12,     0,1,32'h0,32'hE000_0003,0,3);
        add(0,0,1,32'hE000_0004,  0,32'h0,     0,0,32'h0,32'h0,0,0);
        add(0,0,1,32'hE000_0005,  0,32'h0,     0,0,32'h0,32'h0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].r0, vecs[i].r1, vecs[i].ack, vecs[i].dat);
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_adr, vecs[i].e_a0,
                      vecs[i].e_a1, vecs[i].e_d0, vecs[i].e_d1, vecs[i].e_w0, vecs[i].e_w1);
            tick();
        end

        // Simultaneous requests after reset: port 0 first, port 1 straight from DRAIN.
        do_reset();
        drive(1, 1, 0, 32'h0);
        check_all("sim.idle", 1'b0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 2'd0);
        tick();
        burst("sim.p0", 0, 1, 1, A0);
        drive(0, 1, 0, 32'h0);
        check_all("sim.drain", 1'b0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 2'd0);
        tick();
        burst("sim.p1", 1, 0, 1, B1);

        // Continuous requests for four lines: grants alternate, drain acks ignored.
        do_reset();
        drive(1, 1, 0, 32'h0);
        tick();
        for (int line = 0; line < 4; line++) begin
            int own;
            own = line % 2;
            burst($sformatf("alt%0d", line), own, 1, 1, (own == 0) ? A0 : B1);
            drive(own != 0, own == 0, 1'b1, 32'hBAD0_0000);
            check_all($sformatf("alt%0d.drain", line), 1'b0, 32'd0, 0, 0, 32'd0, 32'd0,
                      2'd0, 2'd0);
            tick();
        end

        // Round-robin pointer in IDLE: after a port 0 line, port 1 wins a tie.
        do_reset();
        drive(1, 0, 0, 32'h0);
        tick();
        burst("rr.p0", 0, 1, 0, A0);
        drive(0, 0, 0, 32'h0);
        tick();
        drive(1, 1, 0, 32'h0);
        check_all("rr.idle", 1'b0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 2'd0);
        tick();
        drive(1, 1, 0, 32'h0);
        check_all("rr.gnt1", 1'b1, B1, 0, 0, 32'd0, 32'd0, 2'd0, 2'd0);
        tick();

        // Reset after two beats: outputs clear without an edge; restart at word 0.
        do_reset();
        drive(1, 0, 0, 32'h0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 1, 32'hC000_0000 + 32'(k));
            tick();
        end
        ack_mem2arb = 1'b1; dat_mem2arb = 32'hC000_0002;
        #1;
        check_all("rstmid.pre", 1'b1, A0 + 8, 1, 0, 32'hC000_0002, 32'd0, 2'd2, 2'd0);
        rst = 1'b0;
        #1;
        check_all("rstmid.async", 1'b0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 2'd0);
        tick();
        @(negedge clk);
        check_all("rstmid.hold", 1'b0, 32'd0, 0, 0, 32'd0, 32'd0, 2'd0, 2'd0);
        rst = 1'b1;
        ack_mem2arb = 1'b0;
        tick();
        burst("rstmid.new", 0, 1, 0, A0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound on simulation time.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width.
- WORD_OFFSET, 2, log2 of words per line; a burst is 2^WORD_OFFSET beats.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, reset; asynchronous and active-low.
- req_c0, in, 1, requester 0 line-refill request; held high until its last beat is acked.
- adr_c0, in, ADR_WIDTH, requester 0 miss address; stable while req_c0 is high.
- ack_c0, out, 1, beat valid for requester 0.
- dat_c0, out, DATA_WIDTH, beat data for requester 0.
- word_c0, out, WORD_OFFSET, beat word index for requester 0.
- req_c1, adr_c1, ack_c1, dat_c1, word_c1: identical set for requester 1.
- req_arb2mem, out, 1, memory word-read request.
- adr_arb2mem, out, ADR_WIDTH, memory word address.
- ack_mem2arb, in, 1, one-cycle pulse; data valid for the current word.
- dat_mem2arb, in, DATA_WIDTH, memory read data.

Function
REQ-003 The FSM shall have exactly four states: IDLE, GNT0, GNT1, DRAIN. It shall also hold a beat counter cnt (WORD_OFFSET bits), an owner bit, and a round-robin pointer rr.
REQ-004 In IDLE with exactly one req_cx high, the FSM shall enter GNTx on the next edge, set owner=x and set cnt=0.
REQ-005 In IDLE with both requests high, the FSM shall grant the port indicated by rr; rr=0 favours port 0.
REQ-006 In GNTx, req_arb2mem shall be 1.
REQ-007 In GNTx, adr_arb2mem shall be {adr_cx[ADR_WIDTH-1:WORD_OFFSET+2], cnt, 2'b00}.
REQ-008 In every state other than GNTx, req_arb2mem shall be 0 and adr_arb2mem shall be 0.
REQ-009 In GNTx with ack_mem2arb=1, the block shall set ack_cx=1, dat_cx=dat_mem2arb and word_cx=cnt combinationally in the same cycle, then increment cnt on the next edge.
REQ-010 The non-owner's ack shall be 0 at all times.
REQ-011 dat_cy and word_cy of a non-acked port shall be 0.
REQ-012 When ack_mem2arb arrives with cnt=2^WORD_OFFSET-1, cnt shall wrap to 0, the FSM shall enter DRAIN and rr shall be set to the opposite of owner.
REQ-013 DRAIN shall hold until the owner's req is low.
REQ-014 When the owner's req is low in DRAIN and the other port is requesting, the FSM shall go directly to its GNT state. Otherwise it shall go to IDLE.
REQ-015 ack_mem2arb shall be ignored in IDLE and DRAIN, with no ack forwarded and no state change.
REQ-016 If the owner drops its req mid-burst, the burst shall still complete; all remaining beats shall be forwarded to the owner.
REQ-017 A request arriving on the other port during a burst shall wait; it shall not be lost, because requesters hold req.
REQ-018 Grant latency from req rising in IDLE to req_arb2mem=1 shall be one cycle.
REQ-019 No beat shall be dropped or duplicated; exactly 2^WORD_OFFSET acks shall be delivered per grant.

Reset
REQ-020 While rst=0, asynchronously and regardless of state: FSM=IDLE, cnt=0, owner=0, rr=0, req_arb2mem=0, adr_arb2mem=0, all ack_cx=0, dat_cx=0, word_cx=0.
REQ-021 A reset mid-burst shall abandon the burst with no further acks forwarded. Normal operation shall resume on the first edge after rst returns to 1.

Verification
REQ-022 Single requester 0, adr_c0=0x00CC3B40, memory acks 4 beats D0..D3 -> adr_arb2mem sequence 0x00CC3B40/44/48/4C; ack_c0 pulses with word_c0=0,1,2,3 and dat_c0=D0..D3; ack_c1 stays 0; state passes DRAIN then IDLE after req_c0 falls.
REQ-023 req_c0 and req_c1 rise in the same cycle after reset -> port 0 is served first. Port 1 is granted in the cycle after req_c0 falls in DRAIN, without passing through IDLE.
REQ-024 Both ports request continuously for 4 lines -> grants alternate 0,1,0,1; each line receives exactly 4 acks.
REQ-025 ack_mem2arb pulsed while IDLE and while in DRAIN -> no ack_cx, cnt unchanged, state unchanged.
REQ-026 rst driven to 0 after 2 beats of a burst -> outputs are 0 immediately, without waiting for an edge; after release, a new request restarts at word 0.
REQ-027 Requester 1 drops req_c1 after beat 1 -> beats 2 and 3 are still requested and acked on ack_c1; the FSM then goes DRAIN, then IDLE.
